fifo_reader8: RTL and testbench
===============================

FIFO_READER8 -- requirements
Module: fifo_reader8

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have ports: d_in0..d_in7  input  32 each  storage entries 0..7 from the 8x32 register bank.
REQ-004 SHALL have port: push  input  1  writer committed one word into the entry at tail this cycle.
REQ-005 SHALL have port: rd_en  input  1  read request, one word per asserted cycle.
REQ-006 SHALL have port: d_out  output  32  read data.
REQ-007 SHALL have port: rd_ack  output  1  one-cycle pulse, accepted read, d_out valid.
REQ-008 SHALL have port: rd_err  output  1  one-cycle pulse, read attempted while empty.
REQ-009 SHALL have port: wr_err  output  1  one-cycle pulse, push while full.
REQ-010 SHALL have ports: empty, full  output  1 each  occupancy flags, combinational from data_count.
REQ-011 SHALL have ports: data_count  output  4  occupancy 0..8; head  output  3  next entry to read; tail  output  3  next entry for writer.

Function
REQ-012 SHALL implement FSM states IDLE, READ, RD_ERROR, registered, next state from rd_en and empty at the clock edge.
REQ-013 SHALL transition to READ when rd_en=1 and data_count!=0, to RD_ERROR when rd_en=1 and data_count==0, else IDLE.
REQ-014 SHALL, on accepted read, register d_out <= d_in[head], increment head modulo 8 (7->0), and assert rd_ack the next cycle (1-cycle latency).
REQ-015 SHALL, on read error, keep head, data_count and d_out unchanged and assert rd_err the next cycle.
REQ-016 SHALL, on accepted push (push=1, not full), increment tail modulo 8.
REQ-017 SHALL, on push while full, ignore it (tail, count unchanged) and pulse wr_err the next cycle.
REQ-018 SHALL update data_count: +1 push only, -1 read only, unchanged for push and read together.
REQ-019 SHALL treat simultaneous push and rd_en with data_count==0 as read error plus accepted push (count 0->1).
REQ-020 SHALL treat simultaneous push and rd_en with data_count==8 as accepted read plus accepted push (count stays 8, no wr_err).
REQ-021 SHALL never drive data_count above 8 or below 0.
REQ-022 SHALL assert empty iff data_count==0 and full iff data_count==8.

Reset
REQ-023 SHALL, while reset_n=0 at a clock edge, set state IDLE, head=0, tail=0, data_count=0, d_out=0, rd_ack=0, rd_err=0, wr_err=0.
REQ-024 SHALL abort any read or push in the reset cycle; empty=1, full=0 the cycle after reset.

Configuration
REQ-025 SHALL use macro FIFO_READER_FWFT_EN to select first-word-fall-through.
REQ-026 SHALL, with FIFO_READER_FWFT_EN defined, drive d_out combinationally as d_in[head] whenever not empty (0 when empty); rd_en only advances head, rd_ack same-cycle combinational (rd_en and not empty).
REQ-027 SHALL, without FIFO_READER_FWFT_EN, behave per REQ-014 (registered d_out, 1-cycle latency).

Structure
REQ-028 SHALL place DEPTH=8, WIDTH=32, AW=3, CW=4 and FSM state encodings in shared package fifo_pkg.
REQ-029 SHALL instantiate one sub-module mux8_32 (8-to-1, 32-bit, 3-bit select) for entry selection; pointer/count/FSM logic in fifo_reader8.

Verification
REQ-030 SHALL cover: reset, then rd_en=1 one cycle -> rd_err pulse next cycle, data_count=0, empty=1, head=0.
REQ-031 SHALL cover: 3 pushes with d_in0..2=0xA0,0xA1,0xA2, then 3 reads -> d_out 0xA0,0xA1,0xA2 each with rd_ack, count 3->0, empty=1.
REQ-032 SHALL cover: 8 pushes -> full=1, count=8; 9th push -> wr_err pulse, tail=0, count=8.
REQ-033 SHALL cover: 8 pushes, 8 reads, 2 pushes, 2 reads -> head wraps 7->0 -> 1 -> 2, d_out=d_in0 then d_in1.
REQ-034 SHALL cover: count=0, push and rd_en together -> rd_err=1, count=1; count=8, push and rd_en together -> rd_ack=1, count=8, wr_err=0.
REQ-035 SHALL cover: count=5, reset_n=0 one cycle with rd_en=1 -> count=0, head=tail=0, no rd_ack, d_out=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing constants and FSM state encoding for the
// fifo_reader8 read-side controller.
//   DEPTH - number of storage entries
//   WIDTH - data word width
//   AW    - entry pointer width (head/tail)
//   CW    - occupancy counter width (holds 0..DEPTH)
package fifo_pkg;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    RD_ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_reader8_if.sv
// fifo_reader8_if: read/push handshake and status bundle of fifo_reader8.
//   push, rd_en          - requests from the user side
//   d_out, rd_ack        - read data and acceptance pulse
//   rd_err, wr_err       - underflow / overflow pulses
//   empty, full          - occupancy flags
//   data_count           - occupancy 0..8
//   head, tail           - next entry to read / next entry for the writer
// Modports: master = user side (drives push/rd_en), slave = fifo_reader8.
interface fifo_reader8_if;
  import fifo_pkg::*;

  logic             push;
  logic             rd_en;
  logic [WIDTH-1:0] d_out;
  logic             rd_ack;
  logic             rd_err;
  logic             wr_err;
  logic             empty;
  logic             full;
  logic [CW-1:0]    data_count;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  modport master (
    output push, rd_en,
    input  d_out, rd_ack, rd_err, wr_err, empty, full, data_count, head, tail
  );

  modport slave (
    input  push, rd_en,
    output d_out, rd_ack, rd_err, wr_err, empty, full, data_count, head, tail
  );

endinterface

// File: rtl/mux8_32.sv
// mux8_32: 8-to-1 selector of 32-bit words.
//   in0..in7 - candidate words
//   sel      - 3-bit index
//   y        - selected word
module mux8_32 (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] in3,
  input  logic [31:0] in4,
  input  logic [31:0] in5,
  input  logic [31:0] in6,
  input  logic [31:0] in7,
  input  logic [2:0]  sel,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      3'd0: y = in0;
      3'd1: y = in1;
      3'd2: y = in2;
      3'd3: y = in3;
      3'd4: y = in4;
      3'd5: y = in5;
      3'd6: y = in6;
      3'd7: y = in7;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/fifo_reader8.sv
// fifo_reader8: read-side controller for an 8x32 register-bank FIFO.
// Tracks head/tail/occupancy, serves reads from d_in[head] and flags
// underflow (rd_err) and overflow (wr_err).
//   clk        - rising-edge clock
//   reset_n    - synchronous active-low reset
//   d_in0..7   - storage entries of the register bank
//   bus        - fifo_reader8_if.slave handshake/status bundle
// Build option: define FIFO_READER_FWFT_EN for first-word-fall-through
// (d_out = d_in[head] combinationally, rd_ack same-cycle). Default is a
// registered d_out with rd_ack one cycle after the accepted read.
module fifo_reader8
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_in0,
  input  logic [WIDTH-1:0] d_in1,
  input  logic [WIDTH-1:0] d_in2,
  input  logic [WIDTH-1:0] d_in3,
  input  logic [WIDTH-1:0] d_in4,
  input  logic [WIDTH-1:0] d_in5,
  input  logic [WIDTH-1:0] d_in6,
  input  logic [WIDTH-1:0] d_in7,
  fifo_reader8_if.slave    bus
);

  state_t           state, state_nx;
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic             wr_err_q;
  logic [WIDTH-1:0] head_word;
  logic             empty, full;
  logic             rd_accept, push_accept;

  mux8_32 u_mux (
    .in0 (d_in0),
    .in1 (d_in1),
    .in2 (d_in2),
    .in3 (d_in3),
    .in4 (d_in4),
    .in5 (d_in5),
    .in6 (d_in6),
    .in7 (d_in7),
    .sel (head_q),
    .y   (head_word)
  );

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign rd_accept = bus.rd_en && !empty;
  // A read in the same cycle frees a slot, so a push while full still lands.
  assign push_accept = bus.push && (!full || rd_accept);

  always_comb begin
    state_nx = IDLE;
    if (bus.rd_en) begin
      state_nx = empty ? RD_ERROR : READ;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      // Pointers wrap 7->0 through natural AW-bit overflow.
      head_q   <= head_q + AW'(rd_accept);
      tail_q   <= tail_q + AW'(push_accept);
      wr_err_q <= bus.push && !push_accept;
      case ({push_accept, rd_accept})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FIFO_READER_FWFT_EN
  assign bus.d_out  = empty ? '0 : head_word;
  assign bus.rd_ack = rd_accept;
`else
  logic [WIDTH-1:0] d_out_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_out_q <= '0;
    end else if (rd_accept) begin
      d_out_q <= head_word;
    end
  end

  assign bus.d_out  = d_out_q;
  assign bus.rd_ack = (state == READ);
`endif

  assign bus.rd_err     = (state == RD_ERROR);
  assign bus.wr_err     = wr_err_q;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.data_count = count_q;
  assign bus.head       = head_q;
  assign bus.tail       = tail_q;

endmodule

// File: tb/tb_fifo_reader8.sv
// tb_fifo_reader8: self-checking bench for fifo_reader8 (default build).
// The reference model counts total accepted pushes and reads; occupancy,
// head and tail follow from those totals.
module tb_fifo_reader8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] din [8];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          model_on = 1'b0;
  int          n_push = 0;
  int          n_pop = 0;
  logic [31:0] exp_dout = '0;
  bit          exp_ack = 1'b0;
  bit          exp_rerr = 1'b0;
  bit          exp_werr = 1'b0;

  fifo_reader8_if bus ();

  fifo_reader8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d_in0   (din[0]),
    .d_in1   (din[1]),
    .d_in2   (din[2]),
    .d_in3   (din[3]),
    .d_in4   (din[4]),
    .d_in5   (din[5]),
    .d_in6   (din[6]),
    .d_in7   (din[7]),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the inputs seen at that edge.
  task automatic model_update(input bit p, input bit r, input bit rst);
    int  cnt;
    bit  rd_ok, push_ok;
    if (rst) begin
      model_on = 1'b1;
      n_push   = 0;
      n_pop    = 0;
      exp_dout = '0;
      exp_ack  = 1'b0;
      exp_rerr = 1'b0;
      exp_werr = 1'b0;
    end else begin
      cnt      = n_push - n_pop;
      rd_ok    = r && (cnt > 0);
      push_ok  = p && ((cnt < 8) || rd_ok);
      exp_rerr = r && (cnt == 0);
      exp_werr = p && !push_ok;
      exp_ack  = rd_ok;
      if (rd_ok) exp_dout = din[n_pop % 8];
      n_pop    = n_pop + int'(rd_ok);
      n_push   = n_push + int'(push_ok);
    end
  endtask

  // One clock cycle of stimulus; inputs return to idle right after the edge.
  task automatic step(input bit p, input bit r, input bit rst);
    @(negedge clk);
    #1;
    bus.push  = p;
    bus.rd_en = r;
    reset_n   = !rst;
    @(posedge clk);
    model_update(p, r, rst);
    #1;
    bus.push  = 1'b0;
    bus.rd_en = 1'b0;
    reset_n   = 1'b1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_on) begin
      check("m_count", 32'(bus.data_count), 32'(n_push - n_pop));
      check("m_head",  32'(bus.head),       32'(n_pop % 8));
      check("m_tail",  32'(bus.tail),       32'(n_push % 8));
      check("m_empty", 32'(bus.empty),      32'((n_push - n_pop) == 0));
      check("m_full",  32'(bus.full),       32'((n_push - n_pop) == 8));
      check("m_dout",  bus.d_out,           exp_dout);
      check("m_ack",   32'(bus.rd_ack),     32'(exp_ack));
      check("m_rerr",  32'(bus.rd_err),     32'(exp_rerr));
      check("m_werr",  32'(bus.wr_err),     32'(exp_werr));
    end
  end

  initial begin
    bus.push  = 1'b0;
    bus.rd_en = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    step(0, 0, 1);
    step(0, 0, 1);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full",  32'(bus.full), 0);
    check("rst_count", 32'(bus.data_count), 0);
    check("rst_dout",  bus.d_out, 0);

    // Read while empty
    step(0, 1, 0);
    check("uf_rd_err", 32'(bus.rd_err), 1);
    check("uf_count",  32'(bus.data_count), 0);
    check("uf_empty",  32'(bus.empty), 1);
    check("uf_head",   32'(bus.head), 0);
    step(0, 0, 0);
    check("uf_rd_err_pulse", 32'(bus.rd_err), 0);

    // Three pushes then three reads
    din[0] = 32'hA0; din[1] = 32'hA1; din[2] = 32'hA2;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("p3_count", 32'(bus.data_count), 3);
    check("pin_model_count3", 32'(n_push - n_pop), 3);
    step(0, 1, 0);
    check("r1_dout", bus.d_out, 32'hA0);
    check("r1_ack",  32'(bus.rd_ack), 1);
    step(0, 1, 0);
    check("r2_dout", bus.d_out, 32'hA1);
    step(0, 1, 0);
    check("r3_dout", bus.d_out, 32'hA2);
    check("r3_ack",  32'(bus.rd_ack), 1);
    check("r3_count", 32'(bus.data_count), 0);
    check("r3_empty", 32'(bus.empty), 1);

    // Fill to full, then overflow
    step(0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    check("fill_full",  32'(bus.full), 1);
    check("fill_count", 32'(bus.data_count), 8);
    step(1, 0, 0);
    check("of_wr_err", 32'(bus.wr_err), 1);
    check("of_tail",   32'(bus.tail), 0);
    check("of_count",  32'(bus.data_count), 8);

    // Drain, then wrap the head pointer
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    check("drain_head", 32'(bus.head), 0);
    check("drain_empty", 32'(bus.empty), 1);
    din[0] = 32'h1111_0000; din[1] = 32'h2222_1111;
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    check("wrap_dout0", bus.d_out, 32'h1111_0000);
    check("wrap_head1", 32'(bus.head), 1);
    step(0, 1, 0);
    check("wrap_dout1", bus.d_out, 32'h2222_1111);
    check("wrap_head2", 32'(bus.head), 2);

    // Simultaneous push and read at empty, then at full
    step(1, 1, 0);
    check("sim0_rd_err", 32'(bus.rd_err), 1);
    check("sim0_count",  32'(bus.data_count), 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    check("sim8_pre_full", 32'(bus.full), 1);
    step(1, 1, 0);
    check("sim8_ack",    32'(bus.rd_ack), 1);
    check("sim8_count",  32'(bus.data_count), 8);
    check("sim8_wr_err", 32'(bus.wr_err), 0);
    check("sim8_dout",   bus.d_out, 32'hA2);

    // Reset with a read and push pending
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    check("pin_model_count5", 32'(n_push - n_pop), 5);
    check("pre_rst_count", 32'(bus.data_count), 5);
    step(1, 1, 1);
    check("rr_count", 32'(bus.data_count), 0);
    check("rr_head",  32'(bus.head), 0);
    check("rr_tail",  32'(bus.tail), 0);
    check("rr_ack",   32'(bus.rd_ack), 0);
    check("rr_dout",  bus.d_out, 0);
    check("rr_empty", 32'(bus.empty), 1);
    check("rr_full",  32'(bus.full), 0);

    // Randomized traffic with drifting push/read bias
    for (int i = 0; i < 3000; i++) begin
      int unsigned bias;
      bias = ((i / 300) % 2 == 0) ? 70 : 30;
      din[$urandom_range(0, 7)] = $urandom;
      step($urandom_range(0, 99) < bias,
           $urandom_range(0, 99) < (100 - bias),
           $urandom_range(0, 249) == 0);
    end
    step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
